alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: grants one operation at a time with alternating
// priority, executes it in a fixed IDLE/EXEC/RESP sequence and holds the result.
module alu_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic [2:0]        req0_op,
    input  logic [31:0]       req0_a,
    input  logic [31:0]       req0_b,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [2:0]        req1_op,
    input  logic [31:0]       req1_a,
    input  logic [31:0]       req1_b,
    output logic              req1_ready,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [31:0]       resp_result,
    output logic              resp_zero,
    output logic              resp_err,
    output logic [CNT_W-1:0]  ops_done
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned HALF_W = DATA_W / 2;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b100;
    localparam logic [OP_W-1:0] OP_AND = 3'b001;
    localparam logic [OP_W-1:0] OP_OR  = 3'b101;
    localparam logic [OP_W-1:0] OP_XOR = 3'b010;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic                prio;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                id_q;

    logic                grant0_c;
    logic                grant1_c;
    logic [DATA_W-1:0]   exec_result_c;
    logic                exec_err_c;

    // Grant decision; prio = 1 means requester 1 wins a tie.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (rst_n && (state == IDLE)) begin
            if (req0_valid && (!req1_valid || !prio)) begin
                grant0_c = 1'b1;
            end else if (req1_valid) begin
                grant1_c = 1'b1;
            end
        end
    end

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;

    // Operation decode on the registered operands.
    always_comb begin
        exec_result_c = '0;
        exec_err_c    = 1'b0;
        case (op_q)
            OP_ADD:  exec_result_c = a_q + b_q;
            OP_SUB:  exec_result_c = a_q - b_q;
            OP_AND:  exec_result_c = a_q & b_q;
            OP_OR:   exec_result_c = a_q | b_q;
            OP_XOR:  exec_result_c = a_q ^ b_q;
            OP_SHL:  exec_result_c = {b_q[HALF_W-1:0], HALF_W'(0)};
            default: exec_err_c    = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b1;
            resp_err    <= 1'b0;
            ops_done    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0_c || grant1_c) begin
                        op_q  <= grant1_c ? req1_op : req0_op;
                        a_q   <= grant1_c ? req1_a  : req0_a;
                        b_q   <= grant1_c ? req1_b  : req0_b;
                        id_q  <= grant1_c;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result <= exec_result_c;
                    resp_zero   <= (exec_result_c == '0);
                    resp_err    <= exec_err_c;
                    resp_id     <= id_q;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    // Completion hands priority to the other requester.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        prio       <= ~resp_id;
                        if (ops_done != CNT_MAX) begin
                            ops_done <= ops_done + CNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a default-width instance and a CNT_W=2
// instance share every input so counter saturation is visible alongside.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_ready;

    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_id, resp_zero, resp_err;
    logic [31:0] resp_result;
    logic [15:0] ops_done;

    logic        s_req0_ready, s_req1_ready;
    logic        s_resp_valid, s_resp_id, s_resp_zero, s_resp_err;
    logic [31:0] s_resp_result;
    logic [1:0]  s_ops_done;

    int n_vec = 0;
    int n_err = 0;
    int exp_ops16 = 0;
    int exp_ops2  = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
        .ops_done(ops_done)
    );

    alu_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(s_req1_ready),
        .resp_valid(s_resp_valid), .resp_ready(resp_ready), .resp_id(s_resp_id),
        .resp_result(s_resp_result), .resp_zero(s_resp_zero), .resp_err(s_resp_err),
        .ops_done(s_ops_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        tick();
        exp_ops16 = 0;
        exp_ops2  = 0;
    endtask

    task automatic count_done();
        exp_ops16++;
        if (exp_ops2 < 3) exp_ops2++;
    endtask

    // One uncontended operation through the full IDLE/EXEC/RESP sequence.
    task automatic do_op(input logic id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err);
        set_req(id, 1'b1, op, a, b);
        resp_ready = 1'b1;
        #1;
        check_eq("op_grant", id ? req1_ready : req0_ready, 1);
        check_eq("op_nogrant", id ? req0_ready : req1_ready, 0);
        tick();
        set_req(id, 1'b0, op, a, b);
        check_eq("op_exec_valid", resp_valid, 0);
        tick();
        check_eq("op_resp_valid", resp_valid, 1);
        check_eq("op_result", resp_result, exp_res);
        check_eq("op_id", resp_id, id);
        check_eq("op_zero", resp_zero, exp_res == 32'h0);
        check_eq("op_err", resp_err, exp_err);
        check_eq("op_sat_result", s_resp_result, exp_res);
        tick();
        count_done();
        check_eq("op_done_valid", resp_valid, 0);
        check_eq("op_ops16", ops_done, exp_ops16);
        check_eq("op_ops2", s_ops_done, exp_ops2);
    endtask

    initial begin
        req0_op = '0; req0_a = '0; req0_b = '0;
        req1_op = '0; req1_a = '0; req1_b = '0;

        // Reset state, readys held low while in reset
        apply_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("rst_ready0", req0_ready, 0);
        check_eq("rst_ready1", req1_ready, 0);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_id", resp_id, 0);
        check_eq("rst_result", resp_result, 0);
        check_eq("rst_zero", resp_zero, 1);
        check_eq("rst_err", resp_err, 0);
        check_eq("rst_ops", ops_done, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        // Single op 5+7
        do_op(1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0);

        // Contention from reset: req0 wins, req1 served three cycles later
        apply_reset();
        set_req(1'b0, 1'b1, 3'b100, 32'd3, 32'd3);
        set_req(1'b1, 1'b1, 3'b110, 32'h0, 32'h0000ABCD);
        rst_n = 1'b1;
        #1;
        check_eq("cont_c0_r0", req0_ready, 1);
        check_eq("cont_c0_r1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check_eq("cont_c1_r1", req1_ready, 0);
        tick();
        check_eq("cont_c2_valid", resp_valid, 1);
        check_eq("cont_c2_id", resp_id, 0);
        check_eq("cont_c2_result", resp_result, 0);
        check_eq("cont_c2_zero", resp_zero, 1);
        check_eq("cont_c2_r1", req1_ready, 0);
        tick();
        check_eq("cont_c3_valid", resp_valid, 0);
        check_eq("cont_c3_r1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check_eq("cont_c5_valid", resp_valid, 1);
        check_eq("cont_c5_id", resp_id, 1);
        check_eq("cont_c5_result", resp_result, 32'hABCD0000);
        check_eq("cont_c5_zero", resp_zero, 0);
        tick();
        check_eq("cont_ops", ops_done, 2);

        // Backpressure: held in RESP for five cycles, then priority passes to req1
        set_req(1'b0, 1'b1, 3'b001, 32'hF0F0F0F0, 32'hFF00FF00);
        set_req(1'b1, 1'b1, 3'b010, 32'h12345678, 32'h0000FFFF);
        resp_ready = 1'b0;
        #1;
        check_eq("bp_grant0", req0_ready, 1);
        check_eq("bp_nogrant1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_valid", resp_valid, 1);
            check_eq("bp_hold_result", resp_result, 32'hF000F000);
            check_eq("bp_hold_r1", req1_ready, 0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check_eq("bp_release_valid", resp_valid, 1);
        tick();
        check_eq("bp_idle_valid", resp_valid, 0);
        check_eq("bp_idle_r1", req1_ready, 1);
        check_eq("bp_ops", ops_done, 3);
        tick();
        req1_valid = 1'b0;
        tick();
        check_eq("bp_r1_id", resp_id, 1);
        check_eq("bp_r1_result", resp_result, 32'h1234A987);
        tick();
        exp_ops16 = 4;
        exp_ops2  = 3;

        // Wrap-around arithmetic, OR, shift and both undefined codes
        do_op(1'b1, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        do_op(1'b0, 3'b100, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0);
        do_op(1'b1, 3'b101, 32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0, 1'b0);
        do_op(1'b0, 3'b110, 32'h55555555, 32'h1234ABCD, 32'hABCD0000, 1'b0);
        do_op(1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        do_op(1'b0, 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);

        // Reset during EXEC abandons the op and restores priority to req0
        set_req(1'b1, 1'b1, 3'b000, 32'd1, 32'd1);
        #1;
        check_eq("mid_grant1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        check_eq("mid_rst_r0", req0_ready, 0);
        check_eq("mid_rst_r1", req1_ready, 0);
        tick();
        check_eq("mid_valid_a", resp_valid, 0);
        check_eq("mid_ops", ops_done, 0);
        tick();
        check_eq("mid_valid_b", resp_valid, 0);
        rst_n = 1'b1;
        #1;
        check_eq("mid_prio_r0", req0_ready, 1);
        check_eq("mid_prio_r1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_ops16 = 0;
        exp_ops2  = 0;

        // Saturation of the 2-bit counter: 1,2,3,3,3
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, 3'b000, 32'(i), 32'd1, 32'(i + 1), 1'b0);
        end
        check_eq("sat_final2", s_ops_done, 3);
        check_eq("sat_final16", ops_done, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
